// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS write-back path: result-source select and load size.
package mips_pkg;

  typedef enum logic [1:0] {
    WB_SEL_ALU     = 2'd0,
    WB_SEL_LOAD    = 2'd1,
    WB_SEL_LINK    = 2'd2,
    WB_SEL_SPECIAL = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    LOAD_BYTE = 2'd0,
    LOAD_HALF = 2'd1,
    LOAD_WORD = 2'd2,
    LOAD_RSVD = 2'd3
  } load_size_e;

endpackage

// File: rtl/mips_writeback_unit_load_extract.sv
// Little-endian byte/half/word lane extraction with sign/zero extension and alignment check.
module load_extract
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        offset,
  input  logic [1:0]        size,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] data,
  output logic              misalign
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[7:0];
    unique case (offset)
      2'd0: byte_v = word[7:0];
      2'd1: byte_v = word[15:8];
      2'd2: byte_v = word[23:16];
      2'd3: byte_v = word[31:24];
    endcase
    half_v = offset[1] ? word[31:16] : word[15:0];
  end

  // Reserved size behaves exactly like a word load.
  always_comb begin
    data     = word;
    misalign = 1'b0;
    unique case (load_size_e'(size))
      LOAD_BYTE: data = {{(DATA_W-8){is_signed & byte_v[7]}}, byte_v};
      LOAD_HALF: begin
        data     = {{(DATA_W-16){is_signed & half_v[15]}}, half_v};
        misalign = offset[0];
      end
      default:   misalign = (offset != 2'b00);
    endcase
  end

endmodule

// File: rtl/mips_writeback_unit.sv
// MIPS write-back stage: MEM/WB register, result select, register-file write port, retire counter.
module mips_writeback_unit
  import mips_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_stall,
  input  logic                  in_flush,
  input  logic                  in_reg_write,
  input  logic [1:0]            in_wb_sel,
  input  logic [1:0]            in_load_size,
  input  logic                  in_load_signed,
  input  logic [REG_ADDR_W-1:0] in_write_back_destination,
  input  logic [DATA_W-1:0]     in_address,
  input  logic [DATA_W-1:0]     in_read_data,
  input  logic [DATA_W-1:0]     in_link_pc,
  input  logic [DATA_W-1:0]     in_special_data,
  output logic [DATA_W-1:0]     wb_out,
  output logic                  reg_write_out,
  output logic [REG_ADDR_W-1:0] write_back_destination_out,
  output logic                  wb_valid_out,
  output logic                  misalign_out,
  output logic [CNT_W-1:0]      retire_count
);

  logic                  valid_q,       valid_d;
  logic                  reg_write_q,   reg_write_d;
  wb_sel_e               wb_sel_q,      wb_sel_d;
  logic [1:0]            load_size_q,   load_size_d;
  logic                  load_signed_q, load_signed_d;
  logic [REG_ADDR_W-1:0] dest_q,        dest_d;
  logic [DATA_W-1:0]     address_q,     address_d;
  logic [DATA_W-1:0]     read_data_q,   read_data_d;
  logic [DATA_W-1:0]     link_pc_q,     link_pc_d;
  logic [DATA_W-1:0]     special_q,     special_d;
  logic [CNT_W-1:0]      cnt_q,         cnt_d;

  logic [DATA_W-1:0]     load_data;
  logic                  load_misalign;
  logic                  capture;

  assign capture = !in_flush && !in_stall;

  always_comb begin
    valid_d       = valid_q;
    reg_write_d   = reg_write_q;
    wb_sel_d      = wb_sel_q;
    load_size_d   = load_size_q;
    load_signed_d = load_signed_q;
    dest_d        = dest_q;
    address_d     = address_q;
    read_data_d   = read_data_q;
    link_pc_d     = link_pc_q;
    special_d     = special_q;
    // Flush only kills validity; stale fields are masked at the outputs.
    if (in_flush) begin
      valid_d = 1'b0;
    end else if (!in_stall) begin
      valid_d       = in_valid;
      reg_write_d   = in_reg_write;
      wb_sel_d      = wb_sel_e'(in_wb_sel);
      load_size_d   = in_load_size;
      load_signed_d = in_load_signed;
      dest_d        = in_write_back_destination;
      address_d     = in_address;
      read_data_d   = in_read_data;
      link_pc_d     = in_link_pc;
      special_d     = in_special_data;
    end
    cnt_d = cnt_q + CNT_W'(in_valid && capture);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= 1'b0;
      reg_write_q   <= 1'b0;
      wb_sel_q      <= WB_SEL_ALU;
      load_size_q   <= '0;
      load_signed_q <= 1'b0;
      dest_q        <= '0;
      address_q     <= '0;
      read_data_q   <= '0;
      link_pc_q     <= '0;
      special_q     <= '0;
      cnt_q         <= '0;
    end else begin
      valid_q       <= valid_d;
      reg_write_q   <= reg_write_d;
      wb_sel_q      <= wb_sel_d;
      load_size_q   <= load_size_d;
      load_signed_q <= load_signed_d;
      dest_q        <= dest_d;
      address_q     <= address_d;
      read_data_q   <= read_data_d;
      link_pc_q     <= link_pc_d;
      special_q     <= special_d;
      cnt_q         <= cnt_d;
    end
  end

  load_extract #(
    .DATA_W(DATA_W)
  ) u_load_extract (
    .offset    (address_q[1:0]),
    .size      (load_size_q),
    .is_signed (load_signed_q),
    .word      (read_data_q),
    .data      (load_data),
    .misalign  (load_misalign)
  );

  always_comb begin
    wb_out = '0;
    if (valid_q) begin
      unique case (wb_sel_q)
        WB_SEL_ALU:     wb_out = address_q;
        WB_SEL_LOAD:    wb_out = load_data;
        WB_SEL_LINK:    wb_out = link_pc_q;
        WB_SEL_SPECIAL: wb_out = special_q;
      endcase
    end
  end

  assign misalign_out               = valid_q && (wb_sel_q == WB_SEL_LOAD) && load_misalign;
  assign reg_write_out              = valid_q && reg_write_q && (dest_q != '0) && !misalign_out;
  assign write_back_destination_out = valid_q ? dest_q : '0;
  assign wb_valid_out               = valid_q;
  assign retire_count               = cnt_q;

endmodule
